selectable_output_xfade: RTL and testbench

Parametrised N:1 signed output multiplexer with a hold code. Selection changes produce a linear crossfade from the old channel to the new one over 2^RAMP_LOG2 clocks, so no step transient reaches the downstream DAC or servo input. The block sits between the servo/monitor signal sources and each output DAC channel. It replaces the fixed 15-channel, 16-bit selector.

---
 rtl/selectable_output_xfade_pkg.sv | 19 +
 rtl/selectable_output_xfade_if.sv | 32 +++
 rtl/selectable_output_xfade_fade_interp.sv | 30 +++
 rtl/selectable_output_xfade.sv | 130 +++++++++++++
 tb/tb_selectable_output_xfade.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/selectable_output_xfade_pkg.sv
// Shared types and helpers for the selectable output crossfade block.
package selectable_output_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_t;

  // Select width large enough to address every channel plus the hold code.
  function automatic int sel_width(input int n_ch);
    return $clog2(n_ch + 1);
  endfunction

  // The all-ones select code never addresses a channel and always means hold.
  function automatic int hold_code(input int sel_w);
    return (1 << sel_w) - 1;
  endfunction

endpackage

// File: rtl/selectable_output_xfade_if.sv
// Bundles the select request, channel bus and output status of one output selector.
interface selectable_output_xfade_if
  import selectable_output_pkg::*;
#(
  parameter int N_CH  = 15,
  parameter int W     = 16,
  parameter int SEL_W = sel_width(N_CH)
);

  logic [SEL_W-1:0]    sel;
  logic [N_CH*W-1:0]   in_bus;
  logic signed [W-1:0] out;
  logic [SEL_W-1:0]    cur_sel;
  logic                busy;

  modport master (
    output sel,
    output in_bus,
    input  out,
    input  cur_sel,
    input  busy
  );

  modport slave (
    input  sel,
    input  in_bus,
    output out,
    output cur_sel,
    output busy
  );

endinterface

// File: rtl/selectable_output_xfade_fade_interp.sv
// Combinational linear interpolation a + floor((b-a)*k / 2^RAMP_LOG2).
module fade_interp #(
  parameter int W         = 16,
  parameter int RAMP_LOG2 = 6
) (
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  input  logic [RAMP_LOG2:0]    k,
  output logic signed [W-1:0]   y
);

  localparam int PW = W + 2 + RAMP_LOG2;

  // The result stays between a and b for 0 <= k <= 2^RAMP_LOG2, so plain
  // truncation back to W bits never wraps.
  function automatic logic signed [W-1:0] lerp(
    input logic signed [W-1:0]  fa,
    input logic signed [W-1:0]  fb,
    input logic [RAMP_LOG2:0]   fk
  );
    logic signed [W:0]    diff;
    logic signed [PW-1:0] prod;
    diff = (W+1)'(fb) - (W+1)'(fa);
    prod = PW'(diff) * $signed(PW'(fk));
    return W'(PW'(fa) + (prod >>> RAMP_LOG2));
  endfunction

  assign y = lerp(a, b, k);

endmodule

// File: rtl/selectable_output_xfade.sv
// N:1 signed output selector that crossfades linearly between channels on a select change.
module selectable_output_xfade
  import selectable_output_pkg::*;
#(
  parameter int N_CH      = 15,
  parameter int W         = 16,
  parameter int SEL_W     = sel_width(N_CH),
  parameter int RAMP_LOG2 = 6
) (
  input logic clk,
  input logic rst_n,
  selectable_output_xfade_if.slave bus
);

  localparam logic [SEL_W-1:0]     HOLD    = SEL_W'(hold_code(SEL_W));
  localparam logic [SEL_W-1:0]     N_CH_S  = SEL_W'(N_CH);
  localparam int unsigned          K_END_I = 1 << RAMP_LOG2;
  localparam logic [RAMP_LOG2:0]   K_END   = K_END_I[RAMP_LOG2:0];
  localparam logic [RAMP_LOG2:0]   K_ONE   = (RAMP_LOG2+1)'(1);

  // Channel decode; unused codes read as zero so every select value is in range.
  logic signed [W-1:0] ch [2**SEL_W];
  for (genvar i = 0; i < 2**SEL_W; i++) begin : g_ch
    if (i < N_CH) begin : g_live
      assign ch[i] = bus.in_bus[i*W +: W];
    end else begin : g_none
      assign ch[i] = '0;
    end
  end

  state_t              state, state_n;
  logic [SEL_W-1:0]    prev, prev_n;
  logic [SEL_W-1:0]    cur_sel, cur_n;
  logic [RAMP_LOG2:0]  k, k_n;
  logic [SEL_W-1:0]    pend, pend_n;
  logic                pend_v, pend_v_n;
  logic                busy, busy_n;
  logic signed [W-1:0] out_p1, out_n;
  logic signed [W-1:0] fade_y;
  logic                req_ok;

  fade_interp #(
    .W         (W),
    .RAMP_LOG2 (RAMP_LOG2)
  ) u_interp (
    .a (ch[prev]),
    .b (ch[cur_sel]),
    .k (k),
    .y (fade_y)
  );

  assign req_ok = (bus.sel != HOLD) && (bus.sel < N_CH_S) && (bus.sel != cur_sel);

  // Next-state, pending-request and output-sample selection.
  always_comb begin
    state_n  = state;
    prev_n   = prev;
    cur_n    = cur_sel;
    k_n      = k;
    pend_n   = pend;
    pend_v_n = pend_v;
    busy_n   = busy;
    out_n    = ch[cur_sel];
    case (state)
      IDLE: begin
        if (req_ok) begin
          cur_n = bus.sel;
          if (RAMP_LOG2 != 0) begin
            prev_n  = cur_sel;
            k_n     = K_ONE;
            busy_n  = 1'b1;
            state_n = FADE;
          end
        end
      end
      FADE: begin
        if (k == K_END) begin
          // Final step lands exactly on the target; chain a queued request if any.
          out_n = ch[cur_sel];
          if (pend_v && (pend != cur_sel)) begin
            prev_n   = cur_sel;
            cur_n    = pend;
            k_n      = K_ONE;
            pend_v_n = 1'b0;
          end else begin
            state_n  = IDLE;
            busy_n   = 1'b0;
            pend_v_n = 1'b0;
          end
        end else begin
          out_n = fade_y;
          k_n   = k + K_ONE;
          if (req_ok) begin
            pend_n   = bus.sel;
            pend_v_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---- stage p1: state and output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      prev    <= '0;
      cur_sel <= '0;
      k       <= '0;
      pend    <= '0;
      pend_v  <= 1'b0;
      busy    <= 1'b0;
      out_p1  <= '0;
    end else begin
      state   <= state_n;
      prev    <= prev_n;
      cur_sel <= cur_n;
      k       <= k_n;
      pend    <= pend_n;
      pend_v  <= pend_v_n;
      busy    <= busy_n;
      out_p1  <= out_n;
    end
  end

  assign bus.out     = out_p1;
  assign bus.cur_sel = cur_sel;
  assign bus.busy    = busy;

endmodule

// File: tb/tb_selectable_output_xfade.sv
// Directed bench for selectable_output_xfade: fade build and immediate-switch build.
module tb_selectable_output_xfade;

  localparam int N_CH = 15;
  localparam int W    = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] sel_f, sel_i;
  logic signed [W-1:0] ch_v [N_CH];
  logic [N_CH*W-1:0] in_flat;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N_CH; i++) in_flat[i*W +: W] = ch_v[i];
  end

  selectable_output_xfade_if #(.N_CH(N_CH), .W(W)) bus_f ();
  selectable_output_xfade_if #(.N_CH(N_CH), .W(W)) bus_i ();

  assign bus_f.sel    = sel_f;
  assign bus_f.in_bus = in_flat;
  assign bus_i.sel    = sel_i;
  assign bus_i.in_bus = in_flat;

  selectable_output_xfade #(.N_CH(N_CH), .W(W), .RAMP_LOG2(2)) u_fade (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_f.slave)
  );

  selectable_output_xfade #(.N_CH(N_CH), .W(W), .RAMP_LOG2(0)) u_imm (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i.slave)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic clear_ch();
    for (int i = 0; i < N_CH; i++) ch_v[i] = '0;
  endtask

  int exp_out [9];
  int exp_cur [9];
  int exp_busy [9];

  initial begin
    rst_n = 1'b0;
    sel_f = 4'd0;
    sel_i = 4'd0;
    clear_ch();

    // Reset state
    step();
    step();
    chk("rst_out", bus_f.out, 0);
    chk("rst_cur", bus_f.cur_sel, 0);
    chk("rst_busy", bus_f.busy, 0);
    ch_v[0] = 16'sd100;
    rst_n = 1'b1;
    step();
    chk("rst_first_out", bus_f.out, 100);

    // Basic fade 0 -> 3
    ch_v[0] = 16'sd0;
    ch_v[3] = 16'sd1000;
    sel_f = 4'd3;
    step();
    chk("fade_cur_e0", bus_f.cur_sel, 3);
    chk("fade_busy_e0", bus_f.busy, 1);
    sel_f = 4'd15;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk($sformatf("fade_out_e%0d", e), bus_f.out, 250 * e);
      chk($sformatf("fade_busy_e%0d", e), bus_f.busy, (e < 4) ? 1 : 0);
    end

    // Hold code and same-channel request are ignored
    sel_f = 4'd15;
    step();
    chk("hold_busy", bus_f.busy, 0);
    chk("hold_cur", bus_f.cur_sel, 3);
    sel_f = 4'd3;
    step();
    chk("same_busy", bus_f.busy, 0);
    chk("same_cur", bus_f.cur_sel, 3);
    chk("same_out", bus_f.out, 1000);

    // Floor rounding on a negative ramp
    pulse_reset();
    ch_v[3] = -16'sd3;
    sel_f = 4'd3;
    step();
    sel_f = 4'd15;
    step(); chk("floor_e1", bus_f.out, -1);
    step(); chk("floor_e2", bus_f.out, -2);
    step(); chk("floor_e3", bus_f.out, -3);
    step(); chk("floor_e4", bus_f.out, -3);

    // Pending request chains a second fade with no busy gap
    pulse_reset();
    ch_v[3] = 16'sd1000;
    ch_v[5] = 16'sd2000;
    exp_out  = '{0, 250, 500, 750, 1000, 1250, 1500, 1750, 2000};
    exp_cur  = '{3, 3, 3, 3, 5, 5, 5, 5, 5};
    exp_busy = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    for (int e = 0; e <= 8; e++) begin
      sel_f = (e <= 1) ? 4'd3 : (e == 2) ? 4'd5 : 4'd15;
      step();
      chk($sformatf("pend_out_e%0d", e), bus_f.out, exp_out[e]);
      chk($sformatf("pend_cur_e%0d", e), bus_f.cur_sel, exp_cur[e]);
      chk($sformatf("pend_busy_e%0d", e), bus_f.busy, exp_busy[e]);
    end

    // Asynchronous reset in the middle of a fade
    pulse_reset();
    sel_f = 4'd3;
    step();
    sel_f = 4'd15;
    step();
    step();
    chk("mid_out_e2", bus_f.out, 500);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out", bus_f.out, 0);
    chk("async_busy", bus_f.busy, 0);
    chk("async_cur", bus_f.cur_sel, 0);
    rst_n = 1'b1;

    // Immediate switch build
    sel_i = 4'd3;
    step();
    chk("imm_cur_e0", bus_i.cur_sel, 3);
    chk("imm_busy_e0", bus_i.busy, 0);
    chk("imm_out_e0", bus_i.out, 0);
    sel_i = 4'd15;
    step();
    chk("imm_out_e1", bus_i.out, 1000);
    chk("imm_busy_e1", bus_i.busy, 0);
    step();
    chk("imm_out_e2", bus_i.out, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
